// File: rtl/pmp_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : pmp_seq_checker
// Description : Sequential PMP access checker. Scans one pmpcfg/pmpaddr entry
//               per cycle for a single physical access; the lowest-index match
//               wins. Returns allow/deny, a matched flag and the matching
//               entry index over a valid/ready response channel.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_ENTRIES   number of PMP entries scanned (1..16)
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_addr[31:0]                byte address of the access
//   req_type[1:0]                 00 read, 01 write, 1x exec
//   req_mmode                     1 = M-mode access
//   pmpcfg_i[NUM_ENTRIES*8-1:0]   entry i at [8i+7:8i]: L rsvd[1:0] A[1:0] X W R
//   pmpaddr_i[NUM_ENTRIES*32-1:0] entry i at [32i+31:32i] = addr[33:2]
//   cfg_dirty_i                   pulse on any PMP CSR write
//   rsp_valid/rsp_ready           response handshake
//   rsp_allow, rsp_matched, rsp_entry[IDX_W-1:0]  check result
// Configuration
//   PMP_RESULT_CACHE_EN  when defined, a one-entry result cache lets a repeat
//                        of the last scanned request respond without a scan.
// ============================================================================
module pmp_seq_checker #(
    parameter  int NUM_ENTRIES = 16,
    localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [1:0]                req_type,
    input  logic                      req_mmode,
    input  logic [NUM_ENTRIES*8-1:0]  pmpcfg_i,
    input  logic [NUM_ENTRIES*32-1:0] pmpaddr_i,
    input  logic                      cfg_dirty_i,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_allow,
    output logic                      rsp_matched,
    output logic [IDX_W-1:0]          rsp_entry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ENTRIES - 1);

    state_t           r_state;
    logic [31:0]      r_addr;     // word address, zero-extended
    logic [1:0]       r_type;
    logic             r_mmode;
    logic [IDX_W-1:0] r_idx;

    // Unpack the flat CSR buses so the scan index selects an entry directly.
    logic [7:0]  w_cfg_arr  [NUM_ENTRIES];
    logic [31:0] w_addr_arr [NUM_ENTRIES];

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_unpack
        assign w_cfg_arr[i]  = pmpcfg_i[8*i +: 8];
        assign w_addr_arr[i] = pmpaddr_i[32*i +: 32];
    end

    logic [7:0]       w_cfg;
    logic [31:0]      w_hi;
    logic [31:0]      w_lo;
    logic [31:0]      w_napot_mask;
    logic [IDX_W-1:0] w_idx_m1;
    logic [31:0]      w_req_a;
    logic             w_match;
    logic             w_perm;
    logic             w_allow;
    logic             w_last;

    assign w_cfg        = w_cfg_arr[r_idx];
    assign w_hi         = w_addr_arr[r_idx];
    assign w_idx_m1     = r_idx - IDX_W'(1);
    // TOR lower bound is the previous entry's address, or 0 for entry 0.
    assign w_lo         = (r_idx == '0) ? 32'd0 : w_addr_arr[w_idx_m1];
    // Trailing ones of pmpaddr plus the first zero above them form the mask.
    assign w_napot_mask = w_hi ^ (w_hi + 32'd1);
    assign w_req_a      = {2'b00, req_addr[31:2]};
    assign w_last       = (r_idx == c_last_idx);

    always_comb begin
        w_match = 1'b0;
        case (w_cfg[4:3])
            2'b01:   w_match = (r_addr >= w_lo) && (r_addr < w_hi);
            2'b10:   w_match = (r_addr == w_hi);
            2'b11:   w_match = ((r_addr & ~w_napot_mask) == (w_hi & ~w_napot_mask));
            default: w_match = 1'b0;
        endcase
    end

    always_comb begin
        w_perm = 1'b0;
        case (r_type)
            2'b00:   w_perm = w_cfg[0];
            2'b01:   w_perm = w_cfg[1] & w_cfg[0];   // write without read is denied
            default: w_perm = w_cfg[2];
        endcase
    end

    // Unlocked entries never restrict M-mode.
    assign w_allow   = (r_mmode && !w_cfg[7]) ? 1'b1 : w_perm;
    assign req_ready = (r_state == S_IDLE);

    // Byte offset and reserved cfg bits take no part in the check.
    logic w_unused_bits;
    assign w_unused_bits = ^{req_addr[1:0], w_cfg[6:5]};

`ifdef PMP_RESULT_CACHE_EN
    logic             r_c_valid;
    logic [31:0]      r_c_addr;
    logic [1:0]       r_c_type;
    logic             r_c_mmode;
    logic             r_c_allow;
    logic             r_c_matched;
    logic [IDX_W-1:0] r_c_entry;
    logic             w_hit;

    // A CSR write in the same cycle makes the cached result stale.
    assign w_hit = r_c_valid && !cfg_dirty_i && (r_c_addr == w_req_a) &&
                   (r_c_type == req_type) && (r_c_mmode == req_mmode);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_type      <= '0;
            r_mmode     <= 1'b0;
            r_idx       <= '0;
            rsp_valid   <= 1'b0;
            rsp_allow   <= 1'b0;
            rsp_matched <= 1'b0;
            rsp_entry   <= '0;
`ifdef PMP_RESULT_CACHE_EN
            r_c_valid   <= 1'b0;
            r_c_addr    <= '0;
            r_c_type    <= '0;
            r_c_mmode   <= 1'b0;
            r_c_allow   <= 1'b0;
            r_c_matched <= 1'b0;
            r_c_entry   <= '0;
`endif
        end else begin
`ifdef PMP_RESULT_CACHE_EN
            if (cfg_dirty_i) begin
                r_c_valid <= 1'b0;
            end
`endif
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= w_req_a;
                        r_type  <= req_type;
                        r_mmode <= req_mmode;
                        r_idx   <= '0;
`ifdef PMP_RESULT_CACHE_EN
                        if (w_hit) begin
                            rsp_allow   <= r_c_allow;
                            rsp_matched <= r_c_matched;
                            rsp_entry   <= r_c_entry;
                            rsp_valid   <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            r_state <= S_SCAN;
                        end
`else
                        r_state <= S_SCAN;
`endif
                    end
                end
                S_SCAN: begin
                    if (cfg_dirty_i) begin
                        // Configuration changed under the scan: start over.
                        r_idx <= '0;
                    end else if (w_match || w_last) begin
                        rsp_allow   <= w_match ? w_allow : r_mmode;
                        rsp_matched <= w_match;
                        rsp_entry   <= w_match ? r_idx : '0;
                        rsp_valid   <= 1'b1;
                        r_state     <= S_RESP;
`ifdef PMP_RESULT_CACHE_EN
                        r_c_valid   <= 1'b1;
                        r_c_addr    <= r_addr;
                        r_c_type    <= r_type;
                        r_c_mmode   <= r_mmode;
                        r_c_allow   <= w_match ? w_allow : r_mmode;
                        r_c_matched <= w_match;
                        r_c_entry   <= w_match ? r_idx : '0;
`endif
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmp_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmp_seq_checker
// Description : Directed self-checking bench for pmp_seq_checker with 16
//               entries. Expected results and latencies are hand-computed.
//               Latency expectations for repeated requests follow the
//               PMP_RESULT_CACHE_EN build option.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pmp_seq_checker;

    localparam int NUM_ENTRIES = 16;
`ifdef PMP_RESULT_CACHE_EN
    localparam int c_rep_lat = 1;
`else
    localparam int c_rep_lat = 4;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      req_valid = 1'b0;
    logic                      req_ready;
    logic [31:0]               req_addr = '0;
    logic [1:0]                req_type = '0;
    logic                      req_mmode = 1'b0;
    logic [NUM_ENTRIES*8-1:0]  pmpcfg = '0;
    logic [NUM_ENTRIES*32-1:0] pmpaddr = '0;
    logic                      cfg_dirty = 1'b0;
    logic                      rsp_valid;
    logic                      rsp_ready = 1'b0;
    logic                      rsp_allow;
    logic                      rsp_matched;
    logic [3:0]                rsp_entry;

    int n_vec = 0;
    int n_err = 0;

    pmp_seq_checker #(.NUM_ENTRIES(NUM_ENTRIES)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_type    (req_type),
        .req_mmode   (req_mmode),
        .pmpcfg_i    (pmpcfg),
        .pmpaddr_i   (pmpaddr),
        .cfg_dirty_i (cfg_dirty),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_allow   (rsp_allow),
        .rsp_matched (rsp_matched),
        .rsp_entry   (rsp_entry)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // CSR write model: new values plus a one-cycle dirty pulse, with the DUT idle.
    task automatic clear_cfg();
        @(negedge clk);
        pmpcfg    = '0;
        pmpaddr   = '0;
        cfg_dirty = 1'b1;
        @(negedge clk);
        cfg_dirty = 1'b0;
    endtask

    task automatic set_entry(input int i, input logic [7:0] cfg, input logic [31:0] addr);
        @(negedge clk);
        pmpcfg[8*i +: 8]   = cfg;
        pmpaddr[32*i +: 32] = addr;
        cfg_dirty = 1'b1;
        @(negedge clk);
        cfg_dirty = 1'b0;
    endtask

    // Issues one request; lat = edges from handshake to rsp_valid (0 on timeout).
    // dirty_at: 0 = dirty with the handshake, k>0 = dirty in the cycle after edge E0+k.
    task automatic do_req(input logic [31:0] addr, input logic [1:0] typ, input logic mm,
                          input int dirty_at, output int lat);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        req_addr  = addr;
        req_type  = typ;
        req_mmode = mm;
        req_valid = 1'b1;
        cfg_dirty = (dirty_at == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cfg_dirty = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            cfg_dirty = 1'b0;
            if (rsp_valid) begin
                lat = k;
                break;
            end
            if (k == dirty_at) cfg_dirty = 1'b1;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] addr, input logic [1:0] typ,
                       input logic mm, input int dirty_at, input int exp_lat,
                       input logic exp_allow, input logic exp_matched, input logic [3:0] exp_entry);
        int lat;
        do_req(addr, typ, mm, dirty_at, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_allow"}, rsp_allow, exp_allow);
        check({tag, "_matched"}, rsp_matched, exp_matched);
        check({tag, "_entry"}, rsp_entry, exp_entry);
        take_rsp();
    endtask

    initial begin
        int  lat;
        logic seen;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_allow", rsp_allow, 1'b0);
        check("rst_matched", rsp_matched, 1'b0);
        check("rst_entry", rsp_entry, 4'd0);
        check("rst_req_ready", req_ready, 1'b1);

        // All entries OFF: full scan, M-mode defaults to allow
        run("off_u_read", 32'h0000_1000, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);
        run("off_m_read", 32'h0000_1000, 2'b00, 1'b1, -1, 16, 1'b1, 1'b0, 4'd0);

        // NAPOT 8 KiB at 0x8000_0000, RX
        set_entry(3, 8'h1D, 32'h2000_03FF);
        run("napot_u_exec",  32'h8000_1FFC, 2'b10, 1'b0, -1, 4,  1'b1, 1'b1, 4'd3);
        run("napot_u_write", 32'h8000_1FFC, 2'b01, 1'b0, -1, 4,  1'b0, 1'b1, 4'd3);
        run("napot_u_base",  32'h8000_0000, 2'b11, 1'b0, -1, 4,  1'b1, 1'b1, 4'd3);
        run("napot_u_out",   32'h8000_2000, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);

        // TOR [0x1000,0x2000) RW in entry 1
        clear_cfg();
        set_entry(0, 8'h00, 32'h0000_0400);
        set_entry(1, 8'h0B, 32'h0000_0800);
        run("tor_top",   32'h0000_1FFC, 2'b00, 1'b0, -1, 2,  1'b1, 1'b1, 4'd1);
        run("tor_lo",    32'h0000_1000, 2'b01, 1'b0, -1, 2,  1'b1, 1'b1, 4'd1);
        run("tor_above", 32'h0000_2000, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);
        run("tor_below", 32'h0000_0FFC, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);
        // Empty range (lo >= hi) never matches
        set_entry(0, 8'h00, 32'h0000_0900);
        run("tor_empty", 32'h0000_1FFC, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);
        // TOR at entry 0 has lower bound 0; W without R denies a write
        clear_cfg();
        set_entry(0, 8'h0A, 32'h0000_0010);
        run("tor0_read",  32'h0000_0000, 2'b00, 1'b0, -1, 1, 1'b0, 1'b1, 4'd0);
        run("tor0_write", 32'h0000_003C, 2'b01, 1'b0, -1, 1, 1'b0, 1'b1, 4'd0);

        // Locked NA4 without permissions shadows a later RWX entry, even in M-mode
        clear_cfg();
        set_entry(2, 8'h90, 32'h0000_0C00);
        set_entry(5, 8'h17, 32'h0000_0C00);
        run("lock_m_read",   32'h0000_3000, 2'b00, 1'b1, -1, 3, 1'b0, 1'b1, 4'd2);
        set_entry(2, 8'h10, 32'h0000_0C00);
        run("unlock_m_read", 32'h0000_3000, 2'b00, 1'b1, -1, 3, 1'b1, 1'b1, 4'd2);
        run("unlock_u_read", 32'h0000_3000, 2'b00, 1'b0, -1, 3, 1'b0, 1'b1, 4'd2);
        run("na4_miss",      32'h0000_3004, 2'b00, 1'b0, -1, 16, 1'b0, 1'b0, 4'd0);

        // Response held under back-pressure; a CSR write during RESP changes nothing
        clear_cfg();
        set_entry(3, 8'h1D, 32'h2000_03FF);
        do_req(32'h8000_1FFC, 2'b10, 1'b0, -1, lat);
        check("hold_latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            if (c == 2) cfg_dirty = 1'b1;
            @(posedge clk);
            #1;
            cfg_dirty = 1'b0;
            check("hold_stable", {rsp_valid, rsp_allow, rsp_matched, rsp_entry, req_ready},
                  {1'b1, 1'b1, 1'b1, 4'd3, 1'b0});
        end
        take_rsp();
        check("after_rsp_ready", req_ready, 1'b1);

        // CSR write while scanning entry 2 restarts the scan
        run("dirty_restart", 32'h8000_1FFC, 2'b10, 1'b0, 2, 7, 1'b1, 1'b1, 4'd3);
        // Repeat of the last scanned request
        run("repeat_hit",    32'h8000_1FFC, 2'b10, 1'b0, -1, c_rep_lat, 1'b1, 1'b1, 4'd3);
        // CSR write between requests forces a full scan
        @(negedge clk);
        cfg_dirty = 1'b1;
        @(negedge clk);
        cfg_dirty = 1'b0;
        run("repeat_dirty",  32'h8000_1FFC, 2'b10, 1'b0, -1, 4, 1'b1, 1'b1, 4'd3);
        // CSR write in the handshake cycle itself also forces a scan
        run("hit_same_dirty", 32'h8000_1FFC, 2'b10, 1'b0, 0, 4, 1'b1, 1'b1, 4'd3);
        run("repeat_again",  32'h8000_1FFC, 2'b10, 1'b0, -1, c_rep_lat, 1'b1, 1'b1, 4'd3);
        // Different mode is a different request
        run("other_mode",    32'h8000_1FFC, 2'b10, 1'b1, -1, 4, 1'b1, 1'b1, 4'd3);

        // Reset mid-scan drops the request
        clear_cfg();
        @(negedge clk);
        req_addr  = 32'h0000_1000;
        req_type  = 2'b00;
        req_mmode = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midscan_rst_ready", req_ready, 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("midscan_rst_no_rsp", seen, 1'b0);
        run("post_rst", 32'h0000_1000, 2'b00, 1'b1, -1, 16, 1'b1, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
